// File: rtl/gost_round_ctrl_pkg.sv
// Shared definitions for the GOST 28147-89 round controller and its key selector.
// Holds the round count, round-counter width, subkey index width and FSM encodings.
// No logic here; imported by gost_round_ctrl and gost_key_sel.
package gost_round_ctrl_pkg;

  localparam int GOST_ROUNDS = 32;
  localparam int GOST_CNT_W  = 5;
  localparam int KIDX_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/gost_key_sel.sv
// Purpose: pick the 32-bit GOST subkey for a given round count and key-order direction.
// Latency: purely combinational.
// Backpressure: none; output follows cnt/dec/key immediately.
// Ports: cnt (round counter), dec (1 = decrypt order), key (K7..K0), subkey (selected K_k).
module gost_key_sel
  import gost_round_ctrl_pkg::*;
#(
  parameter int CNT_W = GOST_CNT_W
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             dec,
  input  logic [255:0]     key,
  output logic [31:0]      subkey
);

  logic              rev;
  logic [KIDX_W-1:0] kidx;

  // Encrypt walks K0..K7 three times then K7..K0; decrypt is the exact
  // reverse, i.e. one ascending pass then three descending passes.
  // For a 3-bit index, 7 - x is simply ~x.
  always_comb begin
    rev  = dec ? (cnt >= CNT_W'(8)) : (cnt >= CNT_W'(24));
    kidx = rev ? ~cnt[KIDX_W-1:0] : cnt[KIDX_W-1:0];
  end

  assign subkey = key[{kidx, 5'b00000} +: 32];

endmodule

// File: rtl/gost_round_ctrl.sv
// Purpose: sequences the 32 GOST rounds over an external combinational round datapath.
// Latency: 33 cycles from the accepted istart to the odone pulse, one round per clock.
// Backpressure: istart is only sampled in IDLE; requests while obusy is high are dropped.
// Ports: iclk/irst_n clock and async active-low reset; istart/idec/idata/ikey block request;
//        iround_res datapath result; oround_n1/oround_n2/oround_key datapath operands;
//        odata {N2,N1} result; obusy (RUN or DONE); odone one-cycle completion pulse.
// Build option: define GOST_ROUND_CTRL_DEC_EN to honour idec; otherwise encrypt order only.
module gost_round_ctrl
  import gost_round_ctrl_pkg::*;
#(
  parameter int ROUNDS = GOST_ROUNDS,
  parameter int CNT_W  = GOST_CNT_W
) (
  input  logic         iclk,
  input  logic         irst_n,
  input  logic         istart,
  input  logic         idec,
  input  logic [63:0]  idata,
  input  logic [255:0] ikey,
  input  logic [31:0]  iround_res,
  output logic [31:0]  oround_n1,
  output logic [31:0]  oround_n2,
  output logic [31:0]  oround_key,
  output logic [63:0]  odata,
  output logic         obusy,
  output logic         odone
);

  state_e             state_q, state_d;
  logic [31:0]        n1_q, n1_d;
  logic [31:0]        n2_q, n2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dec_q, dec_d;
  logic               start_dec;
  logic [CNT_W-1:0]   key_cnt;

`ifdef GOST_ROUND_CTRL_DEC_EN
  assign start_dec = idec;
`else
  logic unused_idec;
  assign unused_idec = idec;
  assign start_dec   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    case (state_q)
      ST_IDLE: begin
        if (istart) begin
          n1_d    = idata[31:0];
          n2_d    = idata[63:32];
          cnt_d   = '0;
          dec_d   = start_dec;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_W'(ROUNDS - 1)) begin
          // Final round writes N2 and skips the half swap.
          n2_d    = iround_res;
          state_d = ST_DONE;
        end else begin
          n1_d  = iround_res;
          n2_d  = n1_q;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= ST_IDLE;
      n1_q    <= '0;
      n2_q    <= '0;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
    end
  end

  // Outside RUN the selector sees count 0, which maps to K0 in either order.
  assign key_cnt = (state_q == ST_RUN) ? cnt_q : '0;

  gost_key_sel #(
    .CNT_W (CNT_W)
  ) u_key_sel (
    .cnt    (key_cnt),
    .dec    (dec_q),
    .key    (ikey),
    .subkey (oround_key)
  );

  assign oround_n1 = n1_q;
  assign oround_n2 = n2_q;
  assign odata     = {n2_q, n1_q};
  assign obusy     = (state_q != ST_IDLE);
  assign odone     = (state_q == ST_DONE);

endmodule

// File: tb/tb_gost_round_ctrl.sv
// Bench for gost_round_ctrl: drives a behavioural GOST round datapath and compares
// key order, latency, results and handshake timing against a block-level model.
// Build option GOST_ROUND_CTRL_DEC_EN selects whether decrypt order is expected.
module tb_gost_round_ctrl;

`ifdef GOST_ROUND_CTRL_DEC_EN
  localparam bit DEC_EN = 1'b1;
`else
  localparam bit DEC_EN = 1'b0;
`endif

  // S-box rows; nibble j of row r is S_r(j). Row r acts on nibble r of the sum.
  localparam logic [63:0] SBOX [8] = '{
    64'h35F7C1B6E08D29A4, 64'h95701832AFD6C4BE,
    64'hB9067CFE243AD185, 64'h352BC64EF9801AD7,
    64'h2B30E9A48DF517C6, 64'hEFC95863D1270AB4,
    64'hC2867EA095F314BD, 64'hC8B6E3294A750DF1
  };

  logic         clk;
  logic         rst_n;
  logic         istart;
  logic         idec;
  logic [63:0]  idata;
  logic [255:0] ikey;
  logic [31:0]  iround_res;
  logic [31:0]  oround_n1;
  logic [31:0]  oround_n2;
  logic [31:0]  oround_key;
  logic [63:0]  odata;
  logic         obusy;
  logic         odone;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [31:0] f_round(input logic [31:0] n1, input logic [31:0] k);
    logic [31:0] s;
    logic [31:0] y;
    s = n1 + k;
    y = '0;
    for (int r = 0; r < 8; r++) begin
      y[4*r +: 4] = SBOX[r][{s[4*r +: 4], 2'b00} +: 4];
    end
    return {y[20:0], y[31:21]};
  endfunction

  // Standard schedule: K0..K7 three times then K7..K0; decrypt runs it backwards.
  function automatic int sched(input int i, input bit dec);
    int j;
    j = dec ? (31 - i) : i;
    return (j < 24) ? (j % 8) : (31 - j);
  endfunction

  function automatic logic [63:0] gost_model(input logic [63:0] blk, input logic [255:0] key,
                                             input bit dec);
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] t;
    n1 = blk[31:0];
    n2 = blk[63:32];
    for (int i = 0; i < 32; i++) begin
      t = n2 ^ f_round(n1, key[32*sched(i, dec) +: 32]);
      if (i < 31) begin
        n2 = n1;
        n1 = t;
      end else begin
        n2 = t;
      end
    end
    return {n2, n1};
  endfunction

  // External round datapath.
  assign iround_res = oround_n2 ^ f_round(oround_n1, oround_key);

  gost_round_ctrl dut (
    .iclk       (clk),
    .irst_n     (rst_n),
    .istart     (istart),
    .idec       (idec),
    .idata      (idata),
    .ikey       (ikey),
    .iround_res (iround_res),
    .oround_n1  (oround_n1),
    .oround_n2  (oround_n2),
    .oround_key (oround_key),
    .odata      (odata),
    .obusy      (obusy),
    .odone      (odone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pattern_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = 32'h1111_1111 * i;
    return k;
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // Run one block from IDLE and check load, key order, latency, result and odone width.
  task automatic run_block(input string tag, input logic [63:0] blk, input logic [255:0] key,
                           input bit dec, output logic [63:0] res);
    logic [63:0] exp;
    int n;
    bit seen;
    bit eff_dec;
    eff_dec = dec & DEC_EN;
    exp = gost_model(blk, key, eff_dec);
    ikey   = key;
    idata  = blk;
    idec   = dec;
    istart = 1'b1;
    tick();
    istart = 1'b0;
    idata  = {$urandom, $urandom};
    n = 1;
    chk({tag, "_busy"}, 64'(obusy), 64'd1);
    chk({tag, "_load"}, {oround_n2, oround_n1}, blk);
    seen = 1'b0;
    while (!seen && n < 40) begin
      if (n <= 32)
        chk($sformatf("%s_key_r%0d", tag, n - 1), 64'(oround_key),
            64'(key[32*sched(n - 1, eff_dec) +: 32]));
      tick();
      n++;
      seen = odone;
    end
    chk({tag, "_latency"}, 64'(n), 64'd33);
    chk({tag, "_result"}, odata, exp);
    res = odata;
    tick();
    chk({tag, "_done_width"}, 64'(odone), 64'd0);
    chk({tag, "_idle_busy"}, 64'(obusy), 64'd0);
    chk({tag, "_hold"}, odata, exp);
  endtask

  initial begin
    logic [255:0] key;
    logic [63:0]  ct;
    logic [63:0]  pt;
    logic [63:0]  r;
    logic [63:0]  b1;
    logic [63:0]  b2;
    int n;
    bit seen;
    bit bad_done;

    rst_n  = 1'b0;
    istart = 1'b0;
    idec   = 1'b0;
    idata  = '0;
    ikey   = pattern_key();

    // Reset state.
    #12;
    chk("rst_busy", 64'(obusy), 64'd0);
    chk("rst_done", 64'(odone), 64'd0);
    chk("rst_odata", odata, 64'd0);
    chk("rst_key", 64'(oround_key), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 64'(obusy), 64'd0);

    // Key order with K_i = 0x11111111 * i.
    run_block("enc_order", {$urandom, $urandom}, pattern_key(), 1'b0, r);
    run_block("dec_order", {$urandom, $urandom}, pattern_key(), 1'b1, r);

    // End-to-end on the reference block, then back through decrypt.
    key = 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_DEAD_BEEF_CAFE_F00D_0F1E_2D3C_4B5A_6978;
    run_block("e2e_enc", 64'hFEDC_BA98_7654_3210, key, 1'b0, ct);
    run_block("e2e_dec", ct, key, 1'b1, pt);
    chk("e2e_roundtrip", pt,
        DEC_EN ? 64'hFEDC_BA98_7654_3210 : gost_model(ct, key, 1'b0));

    // Random blocks, keys and directions.
    for (int i = 0; i < 4; i++) begin
      run_block($sformatf("rnd%0d", i), {$urandom, $urandom}, rand_key(), 1'($urandom), r);
    end

    // Reset during RUN aborts with no odone.
    ikey   = rand_key();
    idata  = {$urandom, $urandom};
    istart = 1'b1;
    tick();
    istart = 1'b0;
    bad_done = 1'b0;
    for (int c = 1; c < 10; c++) begin
      tick();
      if (odone) bad_done = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_no_done", 64'(bad_done | odone), 64'd0);
    chk("abort_busy", 64'(obusy), 64'd0);
    chk("abort_odata", odata, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_idle_busy", 64'(obusy), 64'd0);
    chk("abort_idle_done", 64'(odone), 64'd0);
    chk("abort_idle_key", 64'(oround_key), 64'(ikey[31:0]));
    run_block("after_abort", {$urandom, $urandom}, ikey, 1'b0, r);

    // istart held high: ignored while busy, restarts right after DONE.
    key    = rand_key();
    b1     = {$urandom, $urandom};
    b2     = {$urandom, $urandom};
    ikey   = key;
    idec   = 1'b0;
    idata  = b1;
    istart = 1'b1;
    tick();
    idata = b2;
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = odone;
    end
    chk("b2b_lat1", 64'(n), 64'd33);
    chk("b2b_res1", odata, gost_model(b1, key, 1'b0));
    tick();
    chk("b2b_idle_busy", 64'(obusy), 64'd0);
    chk("b2b_idle_hold", odata, gost_model(b1, key, 1'b0));
    tick();
    chk("b2b_restart_busy", 64'(obusy), 64'd1);
    chk("b2b_restart_load", {oround_n2, oround_n1}, b2);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = odone;
    end
    chk("b2b_lat2", 64'(n), 64'd33);
    chk("b2b_res2", odata, gost_model(b2, key, 1'b0));
    istart = 1'b0;
    tick();
    tick();
    chk("b2b_end_busy", 64'(obusy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end, %0d errors so far", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
